sched_rr_dispatcher: RTL and testbench

- Shares the memory schedule engine between NUM_REQ requesters, each presenting an event plus a 32-bit context word.
- Round-robin arbitration picks one requester at a time; its context is decoded into a schedule ID (class 001→1, 010→2, 100→3).
- The ID is issued downstream over a valid/ready handshake, and the block waits for the memory side to report completion.
- Bad contexts and completion timeouts are reported on an error pulse.

---
 rtl/sched_rr_dispatcher_if.sv | 28 ++
 rtl/sched_rr_dispatcher.sv | 184 ++++++++++++++++++
 tb/tb_sched_rr_dispatcher.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sched_rr_dispatcher_if.sv
// Request / schedule-issue / completion bundle between requesters, dispatcher and memory side.
// master = environment (requesters + downstream + memory), slave = dispatcher.
interface sched_rr_dispatcher_if #(
  parameter int NUM_REQ = 4,
  parameter int CTX_W   = 32,
  parameter int SCHED_W = 32
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*CTX_W-1:0] req_context;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     sched_valid;
  logic                     sched_ready;
  logic [SCHED_W-1:0]       sched_id;
  logic [SRC_W-1:0]         sched_src;
  logic                     mem_done;

  modport master (
    output req_valid, req_context, sched_ready, mem_done,
    input  req_ready, sched_valid, sched_id, sched_src
  );

  modport slave (
    input  req_valid, req_context, sched_ready, mem_done,
    output req_ready, sched_valid, sched_id, sched_src
  );
endinterface

// File: rtl/sched_rr_dispatcher.sv
// Round-robin dispatcher: accept -> decode (1 cycle) -> issue (held under backpressure) -> wait for mem_done/timeout.
// Optional SCHED_STATS_EN adds saturating per-ID handshake and error counters.
module sched_rr_dispatcher #(
  parameter int NUM_REQ = 4,
  parameter int CTX_W   = 32,
  parameter int SCHED_W = 32,
  parameter int TIMEOUT = 15,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  sched_rr_dispatcher_if.slave bus,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic                 busy
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]          stat_s1,
  output logic [15:0]          stat_s2,
  output logic [15:0]          stat_s3,
  output logic [15:0]          stat_err
`endif
);

  typedef enum logic [1:0] {IDLE, DECODE, ISSUE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [2:0]         cls_q, cls_d;
  logic               sched_valid_q, sched_valid_d;
  logic [SCHED_W-1:0] sched_id_q, sched_id_d;
  logic               err_pulse_q, err_pulse_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [7:0]         cnt_q, cnt_d;

  logic               grant_vld;
  logic [SRC_W-1:0]   grant_idx;
  logic               handshake;

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_vld && bus.req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = SRC_W'(idx);
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE && grant_vld) ?
                         ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
  assign handshake     = (state_q == ISSUE) && sched_valid_q && bus.sched_ready;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    src_d         = src_q;
    cls_d         = cls_q;
    sched_valid_d = sched_valid_q;
    sched_id_d    = sched_id_q;
    err_pulse_d   = 1'b0;
    err_code_d    = err_code_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          cls_d    = bus.req_context[grant_idx*CTX_W + (CTX_W-3) +: 3];
          src_d    = grant_idx;
          rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        state_d       = ISSUE;
        sched_valid_d = 1'b1;
        case (cls_q)
          3'b001:  sched_id_d = SCHED_W'(1);
          3'b010:  sched_id_d = SCHED_W'(2);
          3'b100:  sched_id_d = SCHED_W'(3);
          default: begin
            sched_valid_d = 1'b0;
            err_pulse_d   = 1'b1;
            err_code_d    = 2'b01;
            state_d       = IDLE;
          end
        endcase
      end
      ISSUE: begin
        if (handshake) begin
          sched_valid_d = 1'b0;
          sched_id_d    = '0;
          cnt_d         = '0;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        // mem_done takes priority over a coincident timeout.
        if (bus.mem_done) begin
          state_d = IDLE;
        end else if (cnt_q == 8'(TIMEOUT-1)) begin
          err_pulse_d = 1'b1;
          err_code_d  = 2'b10;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      src_q         <= '0;
      cls_q         <= '0;
      sched_valid_q <= 1'b0;
      sched_id_q    <= '0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= 2'b00;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      src_q         <= src_d;
      cls_q         <= cls_d;
      sched_valid_q <= sched_valid_d;
      sched_id_q    <= sched_id_d;
      err_pulse_q   <= err_pulse_d;
      err_code_q    <= err_code_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.sched_valid = sched_valid_q;
  assign bus.sched_id    = sched_id_q;
  assign bus.sched_src   = src_q;
  assign err_pulse       = err_pulse_q;
  assign err_code        = err_code_q;
  assign busy            = (state_q != IDLE);

`ifdef SCHED_STATS_EN
  logic [15:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d, se_q, se_d;

  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    se_d = se_q;
    if (handshake && sched_id_q == SCHED_W'(1) && s1_q != 16'hFFFF) s1_d = s1_q + 16'd1;
    if (handshake && sched_id_q == SCHED_W'(2) && s2_q != 16'hFFFF) s2_d = s2_q + 16'd1;
    if (handshake && sched_id_q == SCHED_W'(3) && s3_q != 16'hFFFF) s3_d = s3_q + 16'd1;
    if (err_pulse_d && se_q != 16'hFFFF) se_d = se_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      se_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      se_q <= se_d;
    end
  end

  assign stat_s1  = s1_q;
  assign stat_s2  = s2_q;
  assign stat_s3  = s3_q;
  assign stat_err = se_q;
`endif

endmodule

// File: tb/tb_sched_rr_dispatcher.sv
// Bench for sched_rr_dispatcher: directed scenarios plus a scoreboard of expected (id, src) issues.
module tb_sched_rr_dispatcher;
  localparam int NUM_REQ = 4;
  localparam int CTX_W   = 32;
  localparam int SCHED_W = 32;

  typedef struct {
    logic [SCHED_W-1:0] id;
    logic [1:0]         src;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        err_pulse;
  logic [1:0]  err_code;
  logic        busy;
`ifdef SCHED_STATS_EN
  logic [15:0] stat_s1, stat_s2, stat_s3, stat_err;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  sched_rr_dispatcher_if #(.NUM_REQ(NUM_REQ), .CTX_W(CTX_W), .SCHED_W(SCHED_W)) bus ();

  sched_rr_dispatcher #(.NUM_REQ(NUM_REQ), .CTX_W(CTX_W), .SCHED_W(SCHED_W), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .busy      (busy)
`ifdef SCHED_STATS_EN
    ,
    .stat_s1   (stat_s1),
    .stat_s2   (stat_s2),
    .stat_s3   (stat_s3),
    .stat_err  (stat_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every downstream handshake must match the oldest expected issue.
  always @(negedge clk) begin
    if (!rst && bus.sched_valid && bus.sched_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got id=%0d src=%0d, expected no issue", bus.sched_id, bus.sched_src);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.sched_id !== e.id || bus.sched_src !== e.src) begin
          errors++;
          $display("FAIL sb_issue: got id=%0d src=%0d, expected id=%0d src=%0d",
                   bus.sched_id, bus.sched_src, e.id, e.src);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [SCHED_W-1:0] id, input logic [1:0] src);
    exp_t e;
    e.id  = id;
    e.src = src;
    exp_q.push_back(e);
  endtask

  task automatic set_ctx(input int idx, input logic [CTX_W-1:0] ctx);
    bus.req_context[idx*CTX_W +: CTX_W] = ctx;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid   = '0;
    bus.req_context = '0;
    bus.sched_ready = 1'b0;
    bus.mem_done    = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    checks++; if (bus.sched_valid !== 1'b0) begin errors++; $display("FAIL rst_sched_valid: got %b, expected 0", bus.sched_valid); end
    checks++; if (bus.sched_id !== '0) begin errors++; $display("FAIL rst_sched_id: got %0d, expected 0", bus.sched_id); end
    checks++; if (bus.sched_src !== 2'd0) begin errors++; $display("FAIL rst_sched_src: got %0d, expected 0", bus.sched_src); end
    checks++; if (err_pulse !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL rst_err: got pulse=%b code=%b, expected 0/00", err_pulse, err_code); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    tick();
    set_ctx(2, 32'h2000_0000);
    bus.req_valid   = 4'b0100;
    bus.sched_ready = 1'b1;
    push_exp(1, 2);
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b, expected 0100", bus.req_ready); end
    tick();                                   // accept edge
    bus.req_valid = '0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL single_after_accept: got ready=%b busy=%b, expected 0000/1", bus.req_ready, busy); end
    @(posedge clk);                           // decode edge
    @(negedge clk);
    checks++; if (bus.sched_valid !== 1'b1 || bus.sched_id !== 32'd1 || bus.sched_src !== 2'd2) begin
      errors++; $display("FAIL single_issue: got v=%b id=%0d src=%0d, expected 1/1/2", bus.sched_valid, bus.sched_id, bus.sched_src);
    end
    @(posedge clk);                           // handshake, enter WAIT
    @(negedge clk);
    checks++; if (bus.sched_valid !== 1'b0 || bus.sched_id !== '0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_wait: got v=%b id=%0d busy=%b, expected 0/0/1", bus.sched_valid, bus.sched_id, busy);
    end
    tick();
    tick();
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("FAIL single_done: got busy=%b err=%b, expected 0/0", busy, err_pulse); end
  endtask

  task automatic test_round_robin();
    int seen;
    int guard;
    logic [3:0] exp_rdy;
    logic err_seen;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_ctx(i, 32'h4000_0000 | (32'(i) << 4));
    for (int k = 0; k < 5; k++) push_exp(2, 2'(k % 4));
    bus.req_valid   = 4'b1111;
    bus.sched_ready = 1'b1;
    bus.mem_done    = 1'b1;
    seen = 0;
    guard = 0;
    err_seen = 1'b0;
    while (seen < 5 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (err_pulse) err_seen = 1'b1;
      if (bus.req_ready != 4'b0000) begin
        exp_rdy = 4'b0001 << (seen % 4);
        checks++;
        if (bus.req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant%0d: got %b, expected %b", seen, bus.req_ready, exp_rdy); end
        seen++;
        if (seen == 5) begin
          tick();
          bus.req_valid = '0;
        end
      end
    end
    checks++; if (seen != 5) begin errors++; $display("FAIL rr_timeout: got %0d grants, expected 5", seen); end
    guard = 0;
    while (busy && guard < 50) begin @(negedge clk); guard++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle: got busy=%b, expected 0", busy); end
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL rr_err: got err_pulse seen=%b, expected 0", err_seen); end
    bus.mem_done = 1'b0;
  endtask

  task automatic test_bad_context();
    tick();
    set_ctx(1, 32'h6000_0000);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bad_ready: got %b, expected 0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    @(posedge clk);                           // decode edge
    @(negedge clk);
    checks++; if (err_pulse !== 1'b1 || err_code !== 2'b01 || bus.sched_valid !== 1'b0) begin
      errors++; $display("FAIL bad_err: got pulse=%b code=%b v=%b, expected 1/01/0", err_pulse, err_code, bus.sched_valid);
    end
    @(posedge clk);
    @(negedge clk);
    checks++; if (err_pulse !== 1'b0 || err_code !== 2'b01 || busy !== 1'b0) begin
      errors++; $display("FAIL bad_after: got pulse=%b code=%b busy=%b, expected 0/01/0", err_pulse, err_code, busy);
    end
    bus.req_valid = 4'b1111;                  // rr_ptr should now sit at 2
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bad_rrptr: got %b, expected 0100", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure_timeout();
    int k;
    int hit;
    tick();
    set_ctx(3, 32'h8000_0000);
    bus.req_valid   = 4'b1000;
    bus.sched_ready = 1'b0;
    push_exp(3, 3);
    tick();
    bus.req_valid = '0;
    @(posedge clk);                           // decode edge
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.sched_valid !== 1'b1 || bus.sched_id !== 32'd3 || bus.sched_src !== 2'd3) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b id=%0d src=%0d, expected 1/3/3", c, bus.sched_valid, bus.sched_id, bus.sched_src);
      end
      if (c < 4) @(posedge clk);
    end
    tick();
    bus.sched_ready = 1'b1;
    @(posedge clk);                           // enter WAIT
    k = 0;
    hit = -1;
    while (hit < 0 && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (err_pulse) hit = k;
    end
    checks++; if (hit != 15) begin errors++; $display("FAIL timeout_cycle: got %0d, expected 15", hit); end
    checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL timeout_code: got %b, expected 10", err_code); end
    @(negedge clk);
    checks++; if (err_pulse !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_after: got pulse=%b busy=%b, expected 0/0", err_pulse, busy); end
  endtask

  task automatic test_reset_mid_wait();
    logic err_seen;
    tick();
    set_ctx(1, 32'h2000_0000);
    bus.req_valid   = 4'b0010;
    bus.sched_ready = 1'b1;
    bus.mem_done    = 1'b0;
    push_exp(1, 1);
    tick();                                   // accept
    bus.req_valid = '0;
    @(posedge clk);                           // decode
    @(posedge clk);                           // handshake, enter WAIT
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.sched_valid !== 1'b0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL rmw_state: got busy=%b v=%b err=%b, expected 0/0/0", busy, bus.sched_valid, err_pulse);
    end
    err_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (err_pulse || err_code != 2'b00) err_seen = 1'b1;
    end
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL rmw_noerr: got error seen=%b, expected 0", err_seen); end
    bus.req_valid = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rmw_grant: got %b, expected 0001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

`ifdef SCHED_STATS_EN
  task automatic do_txn(input int src, input logic [CTX_W-1:0] ctx);
    int guard;
    tick();
    set_ctx(src, ctx);
    bus.req_valid   = 4'b0001 << src;
    bus.sched_ready = 1'b1;
    bus.mem_done    = 1'b1;
    tick();
    bus.req_valid = '0;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin @(negedge clk); guard++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL txn_stuck: got busy=%b, expected 0", busy); end
    bus.mem_done = 1'b0;
  endtask

  task automatic test_stats();
    do_reset();
    push_exp(1, 0); do_txn(0, 32'h2000_0000);
    push_exp(1, 1); do_txn(1, 32'h3FFF_FFFF);
    push_exp(3, 2); do_txn(2, 32'h8000_1234);
    do_txn(3, 32'hE000_0000);
    push_exp(1, 3); do_txn(3, 32'h2000_00AA);
    @(negedge clk);
    checks++; if (stat_s1 !== 16'd3) begin errors++; $display("FAIL stat_s1: got %0d, expected 3", stat_s1); end
    checks++; if (stat_s2 !== 16'd0) begin errors++; $display("FAIL stat_s2: got %0d, expected 0", stat_s2); end
    checks++; if (stat_s3 !== 16'd1) begin errors++; $display("FAIL stat_s3: got %0d, expected 1", stat_s3); end
    checks++; if (stat_err !== 16'd1) begin errors++; $display("FAIL stat_err: got %0d, expected 1", stat_err); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_bad_context();
    test_backpressure_timeout();
    test_reset_mid_wait();
`ifdef SCHED_STATS_EN
    test_stats();
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending issues, expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
